// File: rtl/pio_out_sequencer_if.sv
// Bus bundle for pio_out_sequencer: CPU config slave port plus the
// point-to-point write-only master port toward the 8-bit PIO slave.
interface pio_out_sequencer_if;
  logic [3:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;

  // Sequencer side: config slave in, PIO master out
  modport slave (
    input  s_address, s_chipselect, s_write_n, s_writedata,
    output s_readdata, m_address, m_chipselect, m_write_n, m_writedata
  );

  // CPU/PIO side: drives config, observes PIO strobes
  modport master (
    output s_address, s_chipselect, s_write_n, s_writedata,
    input  s_readdata, m_address, m_chipselect, m_write_n, m_writedata
  );
endinterface

// File: rtl/pio_out_sequencer.sv
// PIO output sequencer: plays up to DEPTH byte patterns, one per step,
// INTERVAL+1 cycles apart, with optional looping and a completion irq.
module pio_out_sequencer #(
  parameter int INTERVAL_W = 24,
  parameter int DEPTH      = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  pio_out_sequencer_if.slave bus,
  output logic            irq
);
  typedef enum logic [1:0] {IDLE, STROBE, WAIT} state_t;

  state_t                state, state_nx;
  logic                  run, loop_en, irq_en, done;
  logic [2:0]            last, idx;
  logic [INTERVAL_W-1:0] interval, cnt;
  logic [7:0]            pat [DEPTH];
  logic [7:0]            wd_hold;

  logic wr, ctrl_wr, int_wr, stat_wr, pat_wr;
  logic start, abort, decide, adv, wrap, finish;
  logic unused_wd;

  assign wr      = bus.s_chipselect & ~bus.s_write_n;
  assign ctrl_wr = wr && (bus.s_address == 4'd0);
  assign int_wr  = wr && (bus.s_address == 4'd1);
  assign stat_wr = wr && (bus.s_address == 4'd2);
  assign pat_wr  = wr && bus.s_address[3];
  assign unused_wd = ^bus.s_writedata;

  // State register; async reset drops any strobe immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state and step decision; an abort write beats a same-cycle decision
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    abort    = 1'b0;
    decide   = 1'b0;
    adv      = 1'b0;
    wrap     = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_wr && bus.s_writedata[0]) begin
          start    = 1'b1;
          state_nx = STROBE;
        end
      end
      STROBE, WAIT: begin
        decide = (state == STROBE) ? (interval == '0) : (cnt == '0);
        if (ctrl_wr && !bus.s_writedata[0]) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end else if (decide) begin
          if (idx < last) begin
            adv      = 1'b1;
            state_nx = STROBE;
          end else if (loop_en) begin
            wrap     = 1'b1;
            state_nx = STROBE;
          end else begin
            finish   = 1'b1;
            state_nx = IDLE;
          end
        end else if (state == STROBE) begin
          state_nx = WAIT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Config registers, step index, interval counter and sticky done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run      <= 1'b0;
      loop_en  <= 1'b0;
      irq_en   <= 1'b0;
      last     <= '0;
      interval <= '0;
      idx      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      wd_hold  <= '0;
      for (int i = 0; i < DEPTH; i++) pat[i] <= '0;
    end else begin
      if (ctrl_wr) begin
        run     <= bus.s_writedata[0];
        loop_en <= bus.s_writedata[1];
        irq_en  <= bus.s_writedata[2];
        last    <= bus.s_writedata[6:4];
      end
      // Natural completion always leaves run cleared
      if (finish) run <= 1'b0;
      if (int_wr) interval <= bus.s_writedata[INTERVAL_W-1:0];
      if (pat_wr) pat[bus.s_address[2:0]] <= bus.s_writedata[7:0];
      if (start || wrap) idx <= '0;
      else if (adv)      idx <= idx + 3'd1;
      // INTERVAL is sampled on the strobe cycle; WAIT runs INTERVAL cycles
      if (state == STROBE) begin
        cnt     <= interval - INTERVAL_W'(1);
        wd_hold <= pat[idx];
      end else if (state == WAIT) begin
        cnt <= cnt - INTERVAL_W'(1);
      end
      // Setting done wins over a same-cycle clear
      if (finish) done <= 1'b1;
      else if (start || (stat_wr && bus.s_writedata[1])) done <= 1'b0;
    end
  end

  // Register readback, zero-wait
  always_comb begin
    bus.s_readdata = '0;
    case (bus.s_address)
      4'd0: bus.s_readdata[6:0] = {last, 1'b0, irq_en, loop_en, run};
      4'd1: bus.s_readdata[INTERVAL_W-1:0] = interval;
      4'd2: bus.s_readdata[6:0] = {idx, 2'b00, done, (state != IDLE)};
      default: if (bus.s_address[3]) bus.s_readdata[7:0] = pat[bus.s_address[2:0]];
    endcase
  end

  assign bus.m_address    = 2'd0;
  assign bus.m_chipselect = (state == STROBE);
  assign bus.m_write_n    = (state != STROBE);
  assign bus.m_writedata  = {24'b0, (state == STROBE) ? pat[idx] : wd_hold};
  assign irq              = done & irq_en;
endmodule

// File: doc/pio_out_sequencer.md
# pio_out_sequencer

Avalon-MM controller that drives the 8-bit PIO output slave. It plays back a programmable sequence of up to 8 byte patterns, one pattern per step, at a programmable step interval. It optionally loops the sequence and raises an interrupt on completion. The CPU configures it through its own Avalon-MM slave port. Its master port connects point-to-point to the PIO slave (address/chipselect/write_n/writedata, zero-wait writes), replacing direct CPU writes to that PIO.

## Interface
Parameters:
- INTERVAL_W, 24, width of the step-interval counter/register.
- DEPTH, 8, number of pattern entries (fixed 8; index 3 bits).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- s_address  in  4  config slave word address.
- s_chipselect  in  1  config slave select.
- s_write_n  in  1  config write strobe, active-low.
- s_writedata  in  32  config write data.
- s_readdata  out  32  config read data, combinational, zero wait.
- m_address  out  2  PIO slave address; constant 0.
- m_chipselect  out  1  PIO slave select.
- m_write_n  out  1  PIO slave write strobe, active-low.
- m_writedata  out  32  {24'b0, pattern}.
- irq  out  1  level interrupt = done & irq_en.

## Operation
Register map (slave writes take effect when s_chipselect & ~s_write_n):
- 0 CTRL (RW): bit0 run, bit1 loop, bit2 irq_en, bits[6:4] last (sequence length − 1).
- 1 INTERVAL (RW): bits[INTERVAL_W-1:0].
- 2 STATUS: bit0 busy (RO), bit1 done (sticky; write 1 to bit1 clears it), bits[6:4] current index (RO).
- 8..15 PAT[0..7] (RW): bits[7:0].
- Unmapped addresses read 0 and ignore writes; unused read bits are 0.

States are IDLE, STROBE and WAIT.
- IDLE: busy=0, no master strobes. A CTRL write with bit0=1 sets idx=0, clears done and goes to STROBE.
- STROBE: exactly one cycle with m_chipselect=1, m_write_n=0 and m_writedata={24'b0, PAT[idx]}. INTERVAL is sampled here. The next state is WAIT (INTERVAL>0) or the step decision (INTERVAL=0).
- WAIT: counts INTERVAL cycles, then makes the step decision.
- Step decision:
  - idx<last: idx+1, go to STROBE.
  - idx==last with loop=1: idx=0, go to STROBE.
  - idx==last with loop=0: set done, clear run, go to IDLE.
- Abort: a CTRL write with bit0=0 while busy goes to IDLE at the next edge. No further strobes are issued; done is not set; idx is held for readback.
- A CTRL write with bit0=1 while busy does not restart the sequence. It updates loop, irq_en and last.
- loop and last are evaluated at each step decision. If last is reduced below the current idx, the sequence ends or wraps at the next decision.
- PAT writes are allowed while busy. A new value is used the next time that index is strobed.
- If a done-clear write and the setting of done occur in the same cycle, done=1.

## Timing
- Reset values: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, irq=0. Also CTRL=0, INTERVAL=0, PAT[*]=0, done=0, idx=0, state IDLE.
- Outside STROBE: m_chipselect=0 and m_write_n=1. m_writedata holds its last driven value.
- Start latency: a CTRL run write accepted at edge N gives the first strobe in cycle N+1 (visible after edge N).
- Consecutive strobes are exactly INTERVAL+1 cycles apart. INTERVAL=0 gives a strobe every cycle. Loop wrap adds no extra cycle.
- done and irq rise on the edge that follows the last step decision. This is INTERVAL+1 cycles after the final strobe.
- Asynchronous reset mid-sequence forces IDLE immediately and deasserts m_chipselect without waiting for a clock.

## Test plan
- Reset: assert reset_n=0 mid-STROBE -> m_chipselect=0, m_write_n=1, irq=0, all registers read 0.
- One-shot: PAT[0..2]=0x11,0x22,0x33; INTERVAL=3; CTRL=0x21 -> strobes carry 0x11,0x22,0x33 exactly 4 cycles apart. done=1 and busy=0 follow 4 cycles after the last strobe. irq stays 0 (irq_en=0).
- Loop + irq_en: last=1, loop=1, INTERVAL=0, PAT=0xA5,0x5A -> strobes every cycle alternating 0xA5,0x5A. CTRL bit0=0 -> no strobe after the next edge, done=0, irq=0.
- Completion irq: run last=0, irq_en=1 -> single strobe, then irq=1. Write STATUS bit1=1 -> irq=0.
- Restart ignored: write CTRL run=1 while busy at idx=2 -> sequence continues at idx=3, not 0.
- Live edit: while looping, write PAT[1]=0xFF during WAIT at idx=0 -> next strobe carries 0xFF. Readback of an unmapped address (e.g. 5) -> 0.
